// File: rtl/hangman_pkg.sv
// Shared definitions for the Hangman game sequencer.
// Holds the draw command codes, key code constants, the controller state
// encoding and small key classification helpers.
package hangman_pkg;

    // Draw engine command codes
    localparam logic [2:0] CMD_CLEAR  = 3'd0;
    localparam logic [2:0] CMD_SLOT   = 3'd1;
    localparam logic [2:0] CMD_LETTER = 3'd2;
    localparam logic [2:0] CMD_PART   = 3'd3;
    localparam logic [2:0] CMD_WIN    = 3'd4;
    localparam logic [2:0] CMD_LOSE   = 3'd5;

    // Key codes
    localparam logic [7:0] KEY_NONE    = 8'h00;
    localparam logic [7:0] KEY_ENTER   = 8'h0A;
    localparam logic [7:0] LETTER_A    = 8'h41;
    localparam logic [7:0] LETTER_Z    = 8'h5A;
    localparam logic [7:0] LOWER_A     = 8'h61;
    localparam logic [7:0] LOWER_Z     = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    typedef enum logic [3:0] {
        StInit,
        StEntryPress,
        StEntryRelease,
        StEntryDraw,
        StGuessPress,
        StGuessRelease,
        StCheck,
        StReveal,
        StMissDraw,
        StWin,
        StLose,
        StEnd,
        StEndRelease
    } state_t;

    function automatic logic [7:0] fold_case(input logic [7:0] code);
        if (code >= LOWER_A && code <= LOWER_Z) begin
            return code - CASE_OFFSET;
        end
        return code;
    endfunction

    // Expects an already case-folded code
    function automatic logic is_letter(input logic [7:0] code);
        return (code >= LETTER_A) && (code <= LETTER_Z);
    endfunction

    // States that own an outstanding draw command
    function automatic logic is_draw_state(input state_t st);
        return (st == StInit) || (st == StEntryDraw) || (st == StReveal) ||
               (st == StMissDraw) || (st == StWin) || (st == StLose);
    endfunction

endpackage

// File: rtl/hangman_letter_match.sv
// Combinational letter matcher.
// Ports:
//   guess    - upper-case guessed letter
//   word     - secret word, one byte per slot
//   word_len - number of valid slots
//   match    - bit i set when slot i is valid and holds the guessed letter
module hangman_letter_match #(
    parameter int unsigned MAX_LEN = 10
) (
    input  logic [7:0]               guess,
    input  logic [MAX_LEN-1:0][7:0]  word,
    input  logic [3:0]               word_len,
    output logic [MAX_LEN-1:0]       match
);

    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            match[i] = (word[i] == guess) && (4'(i) < word_len);
        end
    end

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman game sequencer: captures the secret word from key events, runs the
// guess/check loop and issues every screen update to the drawing engine over
// a single req/done handshake.
// Ports:
//   clock, reset         - system clock, synchronous active-high reset
//   key                  - ASCII code of held key, 0 = none
//   draw_done            - engine accepts the current command
//   draw_req/cmd/arg/char- draw command, held stable until accepted
//   word_len             - letters captured
//   reveal_mask          - revealed slots
//   miss_count           - misses so far
//   won, lost            - end-of-game flags
module hangman_game_ctrl
    import hangman_pkg::*;
#(
    parameter int unsigned MAX_LEN    = 10,
    parameter int unsigned MAX_MISSES = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         key,
    input  logic               draw_done,
    output logic               draw_req,
    output logic [2:0]         draw_cmd,
    output logic [3:0]         draw_arg,
    output logic [7:0]         draw_char,
    output logic [3:0]         word_len,
    output logic [MAX_LEN-1:0] reveal_mask,
    output logic [2:0]         miss_count,
    output logic               won,
    output logic               lost
);

    state_t                   state_q, state_d;
    logic [7:0]               key_code_q, key_code_d;
    logic [MAX_LEN-1:0][7:0]  word_q, word_d;
    logic [3:0]               word_len_q, word_len_d;
    logic [7:0]               guess_q, guess_d;
    logic [25:0]              guessed_q, guessed_d;
    logic [MAX_LEN-1:0]       pending_q, pending_d;
    logic [MAX_LEN-1:0]       reveal_q, reveal_d;
    logic [2:0]               miss_q, miss_d;
    logic                     won_q, won_d;
    logic                     lost_q, lost_d;
    logic                     req_q, req_d;
    logic [2:0]               cmd_q, cmd_d;
    logic [3:0]               arg_q, arg_d;
    logic [7:0]               char_q, char_d;

    logic                     hs;
    logic [4:0]               letter_idx;
    logic [MAX_LEN-1:0]       match;
    logic [MAX_LEN-1:0]       len_mask;

    function automatic logic [3:0] lowest_set(input logic [MAX_LEN-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = MAX_LEN - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    hangman_letter_match #(
        .MAX_LEN (MAX_LEN)
    ) u_match (
        .guess    (guess_q),
        .word     (word_q),
        .word_len (word_len_q),
        .match    (match)
    );

    assign letter_idx = 5'(guess_q - LETTER_A);

    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = 4'(i) < word_len_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        key_code_d = key_code_q;
        word_d     = word_q;
        word_len_d = word_len_q;
        guess_d    = guess_q;
        guessed_d  = guessed_q;
        pending_d  = pending_q;
        reveal_d   = reveal_q;
        miss_d     = miss_q;
        won_d      = won_q;
        lost_d     = lost_q;
        req_d      = req_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        char_d     = char_q;
        hs         = req_q & draw_done;

        case (state_q)
            StInit: begin
                if (hs) state_d = StEntryPress;
            end
            StEntryPress: begin
                if (key != KEY_NONE) begin
                    key_code_d = fold_case(key);
                    state_d    = StEntryRelease;
                end
            end
            StEntryRelease: begin
                if (key == KEY_NONE) begin
                    state_d = StEntryPress;
                    if (is_letter(key_code_q)) begin
                        if (word_len_q < 4'(MAX_LEN)) begin
                            word_d[word_len_q] = key_code_q;
                            word_len_d         = word_len_q + 4'd1;
                            state_d            = StEntryDraw;
                        end
                    end else if (key_code_q == KEY_ENTER && word_len_q != 4'd0) begin
                        state_d = StGuessPress;
                    end
                end
            end
            StEntryDraw: begin
                if (hs) state_d = StEntryPress;
            end
            StGuessPress: begin
                if (key != KEY_NONE) begin
                    key_code_d = fold_case(key);
                    state_d    = StGuessRelease;
                end
            end
            StGuessRelease: begin
                if (key == KEY_NONE) begin
                    state_d = StGuessPress;
                    if (is_letter(key_code_q)) begin
                        guess_d = key_code_q;
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (guessed_q[letter_idx]) begin
                    state_d = StGuessPress;
                end else begin
                    guessed_d[letter_idx] = 1'b1;
                    if (|match) begin
                        pending_d = match;
                        state_d   = StReveal;
                    end else begin
                        state_d = StMissDraw;
                    end
                end
            end
            StReveal: begin
                if (hs) begin
                    // arg_q is the slot of the LETTER command just accepted
                    reveal_d[arg_q]  = 1'b1;
                    pending_d[arg_q] = 1'b0;
                    if (pending_d == '0) begin
                        state_d = ((reveal_d | ~len_mask) == '1) ? StWin : StGuessPress;
                    end
                end
            end
            StMissDraw: begin
                if (hs) begin
                    miss_d  = miss_q + 3'd1;
                    state_d = (miss_d == 3'(MAX_MISSES)) ? StLose : StGuessPress;
                end
            end
            StWin: begin
                if (hs) begin
                    won_d   = 1'b1;
                    state_d = StEnd;
                end
            end
            StLose: begin
                if (hs) begin
                    lost_d  = 1'b1;
                    state_d = StEnd;
                end
            end
            StEnd: begin
                if (key != KEY_NONE) state_d = StEndRelease;
            end
            StEndRelease: begin
                if (key == KEY_NONE) begin
                    state_d    = StInit;
                    word_d     = '0;
                    word_len_d = '0;
                    guessed_d  = '0;
                    pending_d  = '0;
                    reveal_d   = '0;
                    miss_d     = '0;
                    won_d      = 1'b0;
                    lost_d     = 1'b0;
                end
            end
            default: state_d = StInit;
        endcase

        // Completion always drops req for a cycle; a draw state entered with
        // req low raises its command on the same edge as the state change.
        if (hs) begin
            req_d = 1'b0;
        end else if (!req_q && is_draw_state(state_d)) begin
            req_d  = 1'b1;
            arg_d  = '0;
            char_d = '0;
            case (state_d)
                StEntryDraw: begin
                    cmd_d = CMD_SLOT;
                    arg_d = word_len_q;
                end
                StReveal: begin
                    cmd_d  = CMD_LETTER;
                    arg_d  = lowest_set(pending_d);
                    char_d = guess_d;
                end
                StMissDraw: begin
                    cmd_d = CMD_PART;
                    arg_d = {1'b0, miss_q} + 4'd1;
                end
                StWin:   cmd_d = CMD_WIN;
                StLose:  cmd_d = CMD_LOSE;
                default: cmd_d = CMD_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StInit;
            key_code_q <= '0;
            word_q     <= '0;
            word_len_q <= '0;
            guess_q    <= '0;
            guessed_q  <= '0;
            pending_q  <= '0;
            reveal_q   <= '0;
            miss_q     <= '0;
            won_q      <= 1'b0;
            lost_q     <= 1'b0;
            req_q      <= 1'b0;
            cmd_q      <= '0;
            arg_q      <= '0;
            char_q     <= '0;
        end else begin
            state_q    <= state_d;
            key_code_q <= key_code_d;
            word_q     <= word_d;
            word_len_q <= word_len_d;
            guess_q    <= guess_d;
            guessed_q  <= guessed_d;
            pending_q  <= pending_d;
            reveal_q   <= reveal_d;
            miss_q     <= miss_d;
            won_q      <= won_d;
            lost_q     <= lost_d;
            req_q      <= req_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            char_q     <= char_d;
        end
    end

    assign draw_req    = req_q;
    assign draw_cmd    = cmd_q;
    assign draw_arg    = arg_q;
    assign draw_char   = char_q;
    assign word_len    = word_len_q;
    assign reveal_mask = reveal_q;
    assign miss_count  = miss_q;
    assign won         = won_q;
    assign lost        = lost_q;

endmodule

// File: tb/tb_hangman_game_ctrl.sv
// Self-checking bench for hangman_game_ctrl: a draw-engine responder pops
// expected commands from a scoreboard queue filled by a small game model.
module tb_hangman_game_ctrl;

    localparam logic [2:0] C_CLEAR = 3'd0, C_SLOT = 3'd1, C_LETTER = 3'd2;
    localparam logic [2:0] C_PART = 3'd3, C_WIN = 3'd4, C_LOSE = 3'd5;

    typedef struct packed {
        logic [2:0] cmd;
        logic [3:0] arg;
        logic [7:0] ch;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] key;
    logic       draw_done;
    logic       draw_req;
    logic [2:0] draw_cmd;
    logic [3:0] draw_arg;
    logic [7:0] draw_char;
    logic [3:0] word_len;
    logic [9:0] reveal_mask;
    logic [2:0] miss_count;
    logic       won, lost;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cmds_seen = 0;
    bit   hold_done = 1'b0;

    // Game model
    logic [7:0]  m_word [10];
    int          m_len;
    logic [25:0] m_guessed;
    logic [9:0]  m_mask;
    int          m_miss;
    logic        m_won, m_lost;

    hangman_game_ctrl #(
        .MAX_LEN    (10),
        .MAX_MISSES (6)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key         (key),
        .draw_done   (draw_done),
        .draw_req    (draw_req),
        .draw_cmd    (draw_cmd),
        .draw_arg    (draw_arg),
        .draw_char   (draw_char),
        .word_len    (word_len),
        .reveal_mask (reveal_mask),
        .miss_count  (miss_count),
        .won         (won),
        .lost        (lost)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fold(input logic [7:0] c);
        if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
        return c;
    endfunction

    function automatic void push(input logic [2:0] cmd, input int arg, input logic [7:0] ch);
        exp_t e;
        e.cmd = cmd;
        e.arg = 4'(arg);
        e.ch  = ch;
        sb.push_back(e);
    endfunction

    function automatic void model_clear();
        m_len = 0; m_guessed = '0; m_mask = '0; m_miss = 0; m_won = 0; m_lost = 0;
        push(C_CLEAR, 0, 8'h00);
    endfunction

    // Draw engine: accepts each new command one half-cycle after it appears
    initial begin : engine
        exp_t e;
        draw_done = 1'b0;
        forever begin
            @(negedge clock);
            if (draw_req && !hold_done && !draw_done) begin
                cmds_seen++;
                if (sb.size() == 0) begin
                    check("unexpected_cmd", 32'(draw_cmd), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("draw_cmd", 32'(draw_cmd), 32'(e.cmd));
                    check("draw_arg", 32'(draw_arg), 32'(e.arg));
                    check("draw_char", 32'(draw_char), 32'(e.ch));
                end
                draw_done = 1'b1;
            end else begin
                draw_done = 1'b0;
            end
        end
    end

    task automatic press(input logic [7:0] code);
        @(negedge clock);
        key = code;
        repeat (3) @(negedge clock);
        key = 8'h00;
        repeat (2) @(negedge clock);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || draw_req) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000) check("idle_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clock);
    endtask

    task automatic do_entry(input logic [7:0] code);
        logic [7:0] c;
        c = fold(code);
        if (c >= 8'h41 && c <= 8'h5A && m_len < 10) begin
            m_word[m_len] = c;
            push(C_SLOT, m_len, 8'h00);
            m_len++;
        end
        press(code);
        wait_idle();
    endtask

    task automatic do_guess(input logic [7:0] code);
        logic [7:0] c;
        int gi;
        bit hit, all;
        c  = fold(code);
        gi = int'(c) - 32'h41;
        if (!m_guessed[gi]) begin
            m_guessed[gi] = 1'b1;
            hit = 0;
            for (int i = 0; i < m_len; i++) begin
                if (m_word[i] == c) begin
                    hit = 1;
                    m_mask[i] = 1'b1;
                    push(C_LETTER, i, c);
                end
            end
            if (hit) begin
                all = 1;
                for (int i = 0; i < m_len; i++) if (!m_mask[i]) all = 0;
                if (all) begin
                    push(C_WIN, 0, 8'h00);
                    m_won = 1;
                end
            end else begin
                m_miss++;
                push(C_PART, m_miss, 8'h00);
                if (m_miss == 6) begin
                    push(C_LOSE, 0, 8'h00);
                    m_lost = 1;
                end
            end
        end
        press(code);
        wait_idle();
    endtask

    task automatic end_game();
        model_clear();
        press(8'h20);
        wait_idle();
    endtask

    task automatic check_state(input string tag);
        check({tag, ".word_len"}, 32'(word_len), 32'(m_len));
        check({tag, ".reveal_mask"}, 32'(reveal_mask), 32'(m_mask));
        check({tag, ".miss_count"}, 32'(miss_count), 32'(m_miss));
        check({tag, ".won"}, 32'(won), 32'(m_won));
        check({tag, ".lost"}, 32'(lost), 32'(m_lost));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".draw_req"}, 32'(draw_req), 32'd0);
        check({tag, ".draw_cmd"}, 32'(draw_cmd), 32'd0);
        check({tag, ".draw_arg"}, 32'(draw_arg), 32'd0);
        check({tag, ".draw_char"}, 32'(draw_char), 32'd0);
        check({tag, ".word_len"}, 32'(word_len), 32'd0);
        check({tag, ".reveal_mask"}, 32'(reveal_mask), 32'd0);
        check({tag, ".miss_count"}, 32'(miss_count), 32'd0);
        check({tag, ".won_lost"}, {30'd0, won, lost}, 32'd0);
    endtask

    initial begin : main
        int seen, n;
        bit stable;
        logic [14:0] held;
        string entry;
        reset = 1'b1;
        key   = 8'h00;
        repeat (3) @(negedge clock);
        check_zero("reset");
        model_clear();
        reset = 1'b0;
        @(negedge clock);
        check("clear_rise", 32'(draw_req), 32'd1);
        wait_idle();

        // Word entry: empty Enter ignored, then "cat"
        do_entry(8'h0A);
        check_state("empty_enter");
        do_entry("c"); do_entry("A"); do_entry("t");
        check_state("cat");
        do_entry(8'h0A);

        // Misses to a loss, with a repeated guess in between
        do_guess("Z");
        seen = cmds_seen;
        do_guess("z");
        check("repeat_no_cmd", 32'(cmds_seen), 32'(seen));
        check_state("repeat");
        do_guess("Q"); do_guess("X"); do_guess("W"); do_guess("V"); do_guess("U");
        check_state("lose");
        end_game();
        check_state("after_lose");

        // "BOOK": multi-slot reveal, then a win
        do_entry("B"); do_entry("O"); do_entry("o"); do_entry("K"); do_entry(8'h0A);
        do_guess("o");
        check_state("book_o");
        do_guess("b"); do_guess("K");
        check_state("win");
        end_game();
        check_state("after_win");

        // Full word plus discarded digit and an over-length letter
        entry = "abc1defghijk";
        for (int i = 0; i < entry.len(); i++) do_entry(entry[i]);
        check_state("max_len");
        do_entry(8'h0A);

        // Engine stalls on a LETTER; command must hold, then reset abandons it
        hold_done = 1'b1;
        press("c");
        n = 0;
        while (!draw_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("held.cmd", 32'(draw_cmd), 32'(C_LETTER));
        check("held.arg", 32'(draw_arg), 32'd2);
        check("held.char", 32'(draw_char), 32'h43);
        held   = {draw_cmd, draw_arg, draw_char};
        stable = 1;
        repeat (50) begin
            @(negedge clock);
            if (!draw_req || {draw_cmd, draw_arg, draw_char} != held) stable = 0;
        end
        check("held.stable", 32'(stable), 32'd1);
        check("held.mask", 32'(reveal_mask), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check_zero("mid_reset");
        model_clear();
        hold_done = 1'b0;
        reset = 1'b0;
        wait_idle();
        check_state("after_reset");
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
